fb_pattern_writer: RTL and testbench

Parametrised framebuffer test-stream generator that feeds the framebuffer writer with one (fb_addr, hit, bri) beat per pixel, row-major over H_RES x V_RES. It adds programmable pacing, downstream backpressure (valid/ready), selectable test patterns, a continuous multi-frame mode and a frame counter. It sits in place of the single-pattern bring-up stimulus at the writer input and asserts swap on the last pixel of each frame.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_pattern_gen.sv | 47 ++++
 rtl/fb_pattern_writer.sv | 203 ++++++++++++++++++++
 tb/tb_fb_pattern_writer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer test-stream generator.
package fb_pkg;

    // Test pattern selected at each frame start
    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        HGRAD   = 2'd1,
        CHECKER = 2'd2,
        HITMASK = 2'd3
    } mode_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACE  = 2'd1,
        OFFER = 2'd2
    } state_t;

    // Solid brightness alternates between frames so a stuck swap is visible
    localparam logic [7:0] SOLID_A = 8'h44;
    localparam logic [7:0] SOLID_B = 8'h33;

    // Counter width for 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_pattern_gen.sv
// Combinational pixel pattern: (x, y, mode, parity) -> (hit, bri).
module fb_pattern_gen
    import fb_pkg::*;
#(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int BRI_W       = 8,
    parameter int CHECK_SHIFT = 4
) (
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    input  mode_t            i_mode,
    input  logic             i_parity,
    output logic             o_hit,
    output logic [BRI_W-1:0] o_bri
);

    logic             w_x_cell;
    logic             w_y_cell;
    logic             w_check;
    logic [BRI_W-1:0] w_solid;
    logic [BRI_W-1:0] w_grad;

    // Lowest bit of the cell index in each axis decides the checker colour
    assign w_x_cell = |((i_x >> CHECK_SHIFT) & X_W'(1));
    assign w_y_cell = |((i_y >> CHECK_SHIFT) & Y_W'(1));
    assign w_check  = w_x_cell ^ w_y_cell;
    assign w_solid  = BRI_W'(i_parity ? SOLID_B : SOLID_A);
    assign w_grad   = BRI_W'(i_x);

    // Pattern select
    always_comb begin
        o_hit = 1'b1;
        o_bri = w_solid;
        case (i_mode)
            SOLID:   o_bri = w_solid;
            HGRAD:   o_bri = w_grad;
            CHECKER: o_bri = w_check ? '1 : '0;
            HITMASK: begin
                o_hit = w_check;
                o_bri = w_solid;
            end
            default: o_bri = w_solid;
        endcase
    end

endmodule

// File: rtl/fb_pattern_writer.sv
// Framebuffer test-stream generator: one beat per pixel, row-major, paced.
// Handshake: a beat is transferred on a rising clk edge where valid && ready;
// while valid is high and ready is low, fb_addr/hit/bri/swap are held stable
// and valid stays high until the transfer happens.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int H_RES       = 600,
    parameter int V_RES       = 600,
    parameter int ADDR_W      = 20,
    parameter int BRI_W       = 8,
    parameter int DIV         = 64,
    parameter int CHECK_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [1:0]        mode,
    input  logic              continuous,
    input  logic              stop,
    input  logic              ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              hit,
    output logic [BRI_W-1:0]  bri,
    output logic              swap,
    output logic              valid,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [1:0]        o_dbg_state
);

    localparam int X_W   = clog2_min1(H_RES);
    localparam int Y_W   = clog2_min1(V_RES);
    localparam int DIV_W = clog2_min1(DIV + 1);
    localparam logic [X_W-1:0]    X_MAX      = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_RES * V_RES - 1);
    // From go, PACE alone spans DIV cycles; after a transfer the OFFER cycle
    // itself counts, so the reload is one lower to keep a DIV-cycle beat period.
    localparam logic [DIV_W-1:0]  DIV_LOAD   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'((DIV >= 2) ? DIV - 2 : 0);

    state_t             r_state;
    state_t             w_next_state;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [ADDR_W-1:0]  r_addr;
    logic [DIV_W-1:0]   r_div;
    mode_t              r_mode;
    logic               r_parity;
    logic               r_stop_pending;
    logic [7:0]         r_frame_cnt;
    logic               r_valid;
    logic               r_hit;
    logic [BRI_W-1:0]   r_bri;
    logic               r_swap;

    logic               w_fire;
    logic               w_last;
    logic               w_restart;
    logic [X_W-1:0]     w_nx;
    logic [Y_W-1:0]     w_ny;
    logic [ADDR_W-1:0]  w_naddr;
    logic [X_W-1:0]     w_gen_x;
    logic [Y_W-1:0]     w_gen_y;
    logic               w_gen_hit;
    logic [BRI_W-1:0]   w_gen_bri;

    assign w_fire    = (r_state == OFFER) && r_valid && ready;
    assign w_last    = (r_x == X_MAX) && (r_y == Y_MAX);
    assign w_restart = continuous && !r_stop_pending && !stop;
    assign w_nx      = (r_x == X_MAX) ? '0 : r_x + X_W'(1);
    assign w_ny      = (r_x == X_MAX) ? r_y + Y_W'(1) : r_y;
    assign w_naddr   = r_addr + ADDR_W'(1);
    // In OFFER the generator looks one pixel ahead for back-to-back beats
    assign w_gen_x   = (r_state == OFFER) ? w_nx : r_x;
    assign w_gen_y   = (r_state == OFFER) ? w_ny : r_y;

    fb_pattern_gen #(
        .X_W         (X_W),
        .Y_W         (Y_W),
        .BRI_W       (BRI_W),
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_gen (
        .i_x      (w_gen_x),
        .i_y      (w_gen_y),
        .i_mode   (r_mode),
        .i_parity (r_parity),
        .o_hit    (w_gen_hit),
        .o_bri    (w_gen_bri)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (go) w_next_state = PACE;
            PACE:  if (r_div == '0) w_next_state = OFFER;
            OFFER: begin
                if (w_fire) begin
                    if (w_last)        w_next_state = w_restart ? PACE : IDLE;
                    else if (DIV == 1) w_next_state = OFFER;
                    else               w_next_state = PACE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy        = (r_state != IDLE);
        o_dbg_state = r_state;
        fb_addr     = r_addr;
        hit         = r_hit;
        bri         = r_bri;
        swap        = r_swap;
        valid       = r_valid;
        frame_cnt   = r_frame_cnt;
    end

    // Pixel counters, pacing divider, frame bookkeeping and beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x            <= '0;
            r_y            <= '0;
            r_addr         <= '0;
            r_div          <= '0;
            r_mode         <= SOLID;
            r_parity       <= 1'b0;
            r_stop_pending <= 1'b0;
            r_frame_cnt    <= '0;
            r_valid        <= 1'b0;
            r_hit          <= 1'b0;
            r_bri          <= '0;
            r_swap         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_mode <= mode_t'(mode);
                        r_x    <= '0;
                        r_y    <= '0;
                        r_addr <= '0;
                        r_div  <= DIV_LOAD;
                    end
                end
                PACE: begin
                    if (stop) r_stop_pending <= 1'b1;
                    if (r_div == '0) begin
                        r_valid <= 1'b1;
                        r_hit   <= w_gen_hit;
                        r_bri   <= w_gen_bri;
                        r_swap  <= (r_addr == LAST_ADDR);
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                OFFER: begin
                    if (stop) r_stop_pending <= 1'b1;
                    if (w_fire) begin
                        if (w_last) begin
                            r_parity    <= ~r_parity;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_valid     <= 1'b0;
                            r_swap      <= 1'b0;
                            if (w_restart) begin
                                r_mode <= mode_t'(mode);
                                r_x    <= '0;
                                r_y    <= '0;
                                r_addr <= '0;
                                r_div  <= DIV_RELOAD;
                            end else begin
                                r_stop_pending <= 1'b0;
                            end
                        end else begin
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_addr <= w_naddr;
                            if (DIV == 1) begin
                                r_hit  <= w_gen_hit;
                                r_bri  <= w_gen_bri;
                                r_swap <= (w_naddr == LAST_ADDR);
                            end else begin
                                r_valid <= 1'b0;
                                r_swap  <= 1'b0;
                                r_div   <= DIV_RELOAD;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer: a paced 4x3 instance and a
// back-to-back 2x2 instance driven from one clock.
module tb_fb_pattern_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: 4x3, DIV=2, CHECK_SHIFT=1 ----------------
    logic       a_rst_n = 1'b0, a_go = 1'b0, a_cont = 1'b0, a_stop = 1'b0, a_ready = 1'b1;
    logic [1:0] a_mode = 2'd0;
    logic [7:0] a_addr, a_bri, a_fcnt;
    logic       a_hit, a_swap, a_valid, a_busy;
    logic [1:0] a_dbg;

    fb_pattern_writer #(
        .H_RES(4), .V_RES(3), .ADDR_W(8), .BRI_W(8), .DIV(2), .CHECK_SHIFT(1)
    ) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .go(a_go), .mode(a_mode), .continuous(a_cont),
        .stop(a_stop), .ready(a_ready), .fb_addr(a_addr), .hit(a_hit), .bri(a_bri),
        .swap(a_swap), .valid(a_valid), .busy(a_busy), .frame_cnt(a_fcnt),
        .o_dbg_state(a_dbg)
    );

    // ---------------- instance B: 2x2, DIV=1 ----------------
    logic       b_rst_n = 1'b0, b_go = 1'b0, b_cont = 1'b0, b_stop = 1'b0, b_ready = 1'b1;
    logic [1:0] b_mode = 2'd0;
    logic [3:0] b_addr;
    logic [7:0] b_bri, b_fcnt;
    logic       b_hit, b_swap, b_valid, b_busy;
    logic [1:0] b_dbg;

    fb_pattern_writer #(
        .H_RES(2), .V_RES(2), .ADDR_W(4), .BRI_W(8), .DIV(1), .CHECK_SHIFT(1)
    ) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .go(b_go), .mode(b_mode), .continuous(b_cont),
        .stop(b_stop), .ready(b_ready), .fb_addr(b_addr), .hit(b_hit), .bri(b_bri),
        .swap(b_swap), .valid(b_valid), .busy(b_busy), .frame_cnt(b_fcnt),
        .o_dbg_state(b_dbg)
    );

    // ---------------- scoreboard for instance A ----------------
    logic [17:0] a_log[$];
    logic [17:0] exp_q[$];
    int          a_frames = 0;

    // Accepted beats: {swap, hit, bri, addr}
    always @(negedge clk) begin
        if (a_valid && a_ready) a_log.push_back({a_swap, a_hit, a_bri, a_addr});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference beat for the 4x3 instance, checker cell = 2 pixels
    function automatic logic [17:0] beat_a(input int addr, input int m, input int par);
        int         x  = addr % 4;
        int         y  = addr / 4;
        logic       ck = ((((x >> 1) ^ (y >> 1)) & 1) != 0);
        logic [7:0] solid = (par != 0) ? 8'h33 : 8'h44;
        logic [7:0] br;
        logic       h = 1'b1;
        case (m)
            0:       br = solid;
            1:       br = 8'(x);
            2:       br = ck ? 8'hFF : 8'h00;
            default: begin br = solid; h = ck; end
        endcase
        return {(addr == 11), h, br, 8'(addr)};
    endfunction

    task automatic push_frame(input int m, input int par, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(beat_a(i, m, par));
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, a_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < a_log.size()) check($sformatf("%s[%0d]", tag, i), a_log[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic a_wait_idle(input string tag, input int budget);
        int n = 0;
        while (a_busy && n < budget) begin tick(); n++; end
        check({tag, "_idle"}, a_busy, 1'b0);
    endtask

    task automatic a_wait_beat(input string tag, input int addr, input int budget);
        int n = 0;
        while (!(a_valid && a_addr == 8'(addr)) && n < budget) begin tick(); n++; end
        check(tag, {a_valid, a_addr}, {1'b1, 8'(addr)});
    endtask

    task automatic a_wait_log(input string tag, input int cnt, input int budget);
        int n = 0;
        while (a_log.size() < cnt && n < budget) begin tick(); n++; end
        check(tag, (a_log.size() >= cnt), 1'b1);
    endtask

    function automatic logic [7:0] log_bri(input int i);
        return (i < a_log.size()) ? a_log[i][15:8] : 8'hxx;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic pat[4];
        int   exp_b, gaps, n_sw, b_frames;
        logic started, seen255;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // ---------------- reset ----------------
        tick(); tick();
        check("rst_valid", a_valid, 1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_addr",  a_addr,  8'd0);
        check("rst_fcnt",  a_fcnt,  8'd0);
        check("rst_swap",  a_swap,  1'b0);
        check("rst_hit",   a_hit,   1'b0);
        check("rst_bri",   a_bri,   8'd0);
        check("rst_state", a_dbg,   2'd0);
        check("rst_b_valid", b_valid, 1'b0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // ---------------- T1: paced solid frame, exact timing ----------------
        a_log.delete();
        a_mode = 2'd0; a_ready = 1'b1; a_go = 1'b1;
        tick();
        a_go = 1'b0;
        check("t1_busy_after_go", a_busy, 1'b1);
        check("t1_no_valid_c1", a_valid, 1'b0);
        tick();
        check("t1_no_valid_c2", a_valid, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t1_valid[%0d]", i), a_valid, 1'b1);
            check($sformatf("t1_addr[%0d]", i), a_addr, 8'(i));
            check($sformatf("t1_bri[%0d]", i), a_bri, 8'h44);
            check($sformatf("t1_hit[%0d]", i), a_hit, 1'b1);
            check($sformatf("t1_swap[%0d]", i), a_swap, (i == 11));
            tick();
            if (i < 11) begin
                check($sformatf("t1_gap[%0d]", i), a_valid, 1'b0);
                check($sformatf("t1_gap_swap[%0d]", i), a_swap, 1'b0);
                tick();
            end
        end
        a_frames = 1;
        check("t1_end_busy", a_busy, 1'b0);
        check("t1_end_valid", a_valid, 1'b0);
        check("t1_end_fcnt", a_fcnt, 8'(a_frames));

        // second frame: parity flips bri; go on the final handshake is ignored
        a_log.delete();
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        a_wait_beat("t1b_first", 0, 8);
        check("t1b_bri", a_bri, 8'h33);
        a_wait_beat("t1b_last", 11, 40);
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        check("t1b_go_end_busy", a_busy, 1'b0);
        tick();
        check("t1b_go_end_busy2", a_busy, 1'b0);
        check("t1b_go_end_valid", a_valid, 1'b0);
        a_frames = 2;
        check("t1b_fcnt", a_fcnt, 8'(a_frames));
        push_frame(0, 1, 12);
        compare_log("t1b_log");

        // ---------------- T3: continuous checker, stop mid-frame ----------------
        a_log.delete();
        a_mode = 2'd2; a_cont = 1'b1; a_go = 1'b1;
        tick();
        a_go = 1'b0;
        a_wait_log("t3_frame1", 12, 60);
        a_wait_beat("t3_addr5", 5, 20);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        a_wait_idle("t3", 60);
        a_cont = 1'b0;
        check("t3_ck_addr0", log_bri(0), 8'h00);
        check("t3_ck_addr2", log_bri(2), 8'hFF);
        check("t3_ck_addr8", log_bri(8), 8'hFF);
        check("t3_ck_addr10", log_bri(10), 8'h00);
        a_frames += 2;
        check("t3_fcnt", a_fcnt, 8'(a_frames));
        push_frame(2, 0, 12);
        push_frame(2, 0, 12);
        compare_log("t3_log");

        // ---------------- T4: mode change mid-frame ----------------
        a_log.delete();
        a_mode = 2'd0; a_cont = 1'b1; a_go = 1'b1;
        tick();
        a_go = 1'b0;
        a_wait_beat("t4_mid", 4, 30);
        a_mode = 2'd1;
        a_wait_log("t4_next_frame", 13, 60);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        a_wait_idle("t4", 60);
        a_cont = 1'b0;
        push_frame(0, a_frames % 2, 12);
        push_frame(1, 0, 12);
        a_frames += 2;
        check("t4_fcnt", a_fcnt, 8'(a_frames));
        compare_log("t4_log");

        // ---------------- T5: go while busy, async reset at addr 6 ----------------
        a_log.delete();
        a_mode = 2'd0; a_go = 1'b1;
        tick();
        a_wait_beat("t5_addr6", 6, 40);
        a_go = 1'b0;
        a_rst_n = 1'b0;
        #2;
        check("t5_rst_valid", a_valid, 1'b0);
        check("t5_rst_addr", a_addr, 8'd0);
        check("t5_rst_fcnt", a_fcnt, 8'd0);
        check("t5_rst_busy", a_busy, 1'b0);
        check("t5_rst_swap", a_swap, 1'b0);
        tick();
        a_rst_n = 1'b1;
        push_frame(0, a_frames % 2, 6);
        compare_log("t5_log");
        a_frames = 0;
        tick();
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        a_wait_beat("t5_restart", 0, 8);
        check("t5_restart_bri", a_bri, 8'h44);
        a_wait_idle("t5", 60);
        a_frames = 1;
        check("t5_fcnt", a_fcnt, 8'(a_frames));

        // ---------------- T2: back-to-back with ready toggling ----------------
        b_mode = 2'd1; b_ready = 1'b1; b_go = 1'b1;
        tick();
        b_go = 1'b0;
        exp_b = 0; gaps = 0; started = 1'b0;
        for (int k = 0; k < 40 && exp_b < 4; k++) begin
            if (b_valid) begin
                started = 1'b1;
                check($sformatf("t2_addr[k%0d]", k), b_addr, 4'(exp_b));
                check($sformatf("t2_bri[k%0d]", k), b_bri, 8'(exp_b % 2));
                check($sformatf("t2_hit[k%0d]", k), b_hit, 1'b1);
                check($sformatf("t2_swap[k%0d]", k), b_swap, (exp_b == 3));
            end else if (started) begin
                gaps++;
            end
            b_ready = pat[k % 4];
            if (b_valid && b_ready) exp_b++;
            tick();
        end
        b_ready = 1'b1;
        check("t2_beats", exp_b, 4);
        check("t2_gaps", gaps, 0);
        check("t2_end_valid", b_valid, 1'b0);
        check("t2_end_busy", b_busy, 1'b0);
        b_frames = 1;
        check("t2_fcnt", b_fcnt, 8'(b_frames));

        // ---------------- T6: frame counter wrap ----------------
        b_mode = 2'd0; b_cont = 1'b1; b_go = 1'b1;
        tick();
        b_go = 1'b0;
        n_sw = 0; seen255 = 1'b0;
        for (int k = 0; k < 4000 && n_sw < 255; k++) begin
            if (b_fcnt == 8'd255) seen255 = 1'b1;
            if (b_valid && b_swap) begin
                n_sw++;
                if (n_sw == 255) b_stop = 1'b1;
            end
            tick();
            b_stop = 1'b0;
        end
        b_cont = 1'b0;
        check("t6_swaps", n_sw, 255);
        check("t6_seen255", seen255, 1'b1);
        check("t6_busy", b_busy, 1'b0);
        check("t6_fcnt_wrap", b_fcnt, 8'((b_frames + 255) % 256));
        tick();
        check("t6_stays_idle", b_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
